// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   md_op_e  : operation codes presented on md_op
//   state_e  : control FSM states
//   is_signed/is_mul/is_div/is_acc : opcode decode helpers
package md_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_MADD  = 3'b110,
      OP_MADDU = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   function automatic logic is_signed(input md_op_e op);
      return op inside {OP_MULT, OP_DIV, OP_MADD};
   endfunction

   function automatic logic is_mul(input md_op_e op);
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
   endfunction

   function automatic logic is_div(input md_op_e op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   function automatic logic is_acc(input md_op_e op);
      return op inside {OP_MADD, OP_MADDU};
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-bit-per-cycle unsigned shift-add multiplier and
// restoring divider sharing a 2*WIDTH accumulator.
//   clk, reset : clock, synchronous active-low reset
//   load       : capture op_a into acc low half, op_b as multiplicand/divisor
//   step       : perform one iteration (mode=1 multiply, mode=0 divide)
//   res        : {high, low} = {product hi, product lo} or {remainder, quotient}
//   last       : the current step is the final (WIDTH-th) iteration
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               mode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [2*WIDTH-1:0] res,
   output logic               last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc_q, acc_nxt;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     psum, rem_sh, rem_new;
   logic               dge;

   always_comb begin
      // multiply: add multiplicand into the high half when the low bit is set, then shift right
      psum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      // divide: shift the next dividend bit into the partial remainder, subtract if it fits
      rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
      dge     = rem_sh >= {1'b0, b_q};
      rem_new = dge ? rem_sh - {1'b0, b_q} : rem_sh;
      if (mode) acc_nxt = {psum, acc_q[WIDTH-1:1]};
      else      acc_nxt = {rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], dge};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= {{WIDTH{1'b0}}, op_a};
         b_q   <= op_b;
         cnt_q <= '0;
      end else if (step) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign res  = acc_q;
   assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO registers.
//   clk, reset : clock, synchronous active-low reset
//   start      : request, sampled only while idle; md_op selects the operation
//   A1, A2     : multiplicand/dividend/move data, multiplier/divisor
//   flush      : abort in-flight op, suppress a same-cycle start
//   busy       : operation in flight; done: 1-cycle pulse when HI/LO are updated
//   HI, LO     : high product / remainder, low product / quotient
import md_pkg::*;

module md_unit #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  md_op,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] A2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   state_e             state, state_nxt;
   md_op_e             op;
   logic               accept, core_load, core_step, core_mode, core_last;
   logic               fix_wr, mt_wr;
   logic               sgn_p, sgn_r, acc_op, div_op, div0;
   logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
   logic [2*WIDTH-1:0] core_res, prod, fix_val;

   assign op     = md_op_e'(md_op[2:0]);
   assign accept = start && !flush;
   // signed ops iterate on magnitudes; MIN maps to itself, which is its correct unsigned magnitude
   assign mag_a  = (is_signed(op) && A1[WIDTH-1]) ? -A1 : A1;
   assign mag_b  = (is_signed(op) && A2[WIDTH-1]) ? -A2 : A2;

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .load  (core_load),
      .step  (core_step),
      .mode  (core_mode),
      .op_a  (mag_a),
      .op_b  (mag_b),
      .res   (core_res),
      .last  (core_last)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               if (is_mul(op))      state_nxt = ST_MUL;
               else if (is_div(op)) state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: if (core_last) state_nxt = ST_FIX;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      core_load = (state == ST_IDLE) && accept && (is_mul(op) || is_div(op));
      mt_wr     = (state == ST_IDLE) && accept && (op == OP_MTHI || op == OP_MTLO);
      core_step = (state == ST_MUL || state == ST_DIV) && !flush;
      core_mode = (state == ST_MUL);
      fix_wr    = (state == ST_FIX) && !flush;
   end

   always_comb begin
      prod = sgn_p ? -core_res : core_res;
      quo  = sgn_p ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0];
      rem  = sgn_r ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH];
      // a zero divisor leaves the remainder equal to the dividend but the quotient must read all-ones
      if (div0) quo = '1;
      if (div_op)      fix_val = {rem, quo};
      else if (acc_op) fix_val = {HI, LO} + prod;
      else             fix_val = prod;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         HI     <= '0;
         LO     <= '0;
         done   <= 1'b0;
         sgn_p  <= 1'b0;
         sgn_r  <= 1'b0;
         acc_op <= 1'b0;
         div_op <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= fix_wr;
         if (core_load) begin
            sgn_p  <= is_signed(op) && (A1[WIDTH-1] ^ A2[WIDTH-1]);
            sgn_r  <= is_signed(op) && A1[WIDTH-1];
            acc_op <= is_acc(op);
            div_op <= is_div(op);
            div0   <= (A2 == '0);
         end
         if (mt_wr) begin
            if (op == OP_MTHI) HI <= A1;
            else               LO <= A1;
         end
         if (fix_wr) {HI, LO} <= fix_val;
      end
   end

endmodule
